dwell_timer: RTL and testbench
==============================

DWELL_TIMER -- requirements
Module: dwell_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of dwell counts and COUNT.
REQ-002 SHALL have parameter TICK_DIV, default 10, CLK cycles per dwell tick (legal range >= 1).
REQ-003 SHALL have parameter DEF_DUR, default 4, reset value of every dwell register.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port CLR  input  1  restart the dwell of the current state.
REQ-007 SHALL have port EN  input  1  tick enable; prescaler and COUNT freeze while low.
REQ-008 SHALL have port S  input  6  one-hot state from sequencer, S[0]=S0 .. S[5]=S5.
REQ-009 SHALL have port WE  input  1  dwell register write strobe.
REQ-010 SHALL have port WADDR  input  3  dwell register index 0..5.
REQ-011 SHALL have port WDATA  input  WIDTH  dwell value in ticks.
REQ-012 SHALL have port Overflow  output  1  one-cycle pulse: dwell of current state expired.
REQ-013 SHALL have port COUNT  output  WIDTH  remaining ticks of current dwell.
REQ-014 SHALL have port ERR  output  1  registered flag: S is not one-hot.

Function
REQ-015 SHALL hold six dwell registers DUR[0..5]; WE writes DUR[WADDR]<=WDATA; WADDR 6,7 ignored.
REQ-016 SHALL register S into S_prev every cycle; reload event = (S != S_prev and S one-hot) or CLR.
REQ-017 SHALL on reload event: COUNT<=DUR[index of S], prescaler<=0, Overflow<=0, no tick processed that cycle.
REQ-018 SHALL forward WDATA to the reload when WE and reload coincide with WADDR = index of S.
REQ-019 SHALL run prescaler 0..TICK_DIV-1 when EN=1, COUNT>0, no ERR; tick = prescaler==TICK_DIV-1 (TICK_DIV=1: tick every enabled cycle).
REQ-020 SHALL on tick decrement COUNT by 1; on tick with COUNT==1 set COUNT<=0 and Overflow<=1.
REQ-021 SHALL make Overflow high for exactly one cycle per dwell; COUNT holds 0 afterward until next reload, no repeat pulse.
REQ-022 SHALL treat DUR=0 as infinite dwell: COUNT=0 after reload, never Overflow.
REQ-023 SHALL when S zero or multi-hot: ERR<=1, COUNT<=0, prescaler<=0, Overflow<=0, CLR ignored; ERR clears the cycle after S returns one-hot, which also triggers a reload.
REQ-024 SHALL keep prescaler value while EN=0; resume counting from it when EN returns high.
REQ-025 SHALL prioritise RST > ERR > reload (CLR/state change) > tick.
REQ-026 SHALL have all outputs registered; latency tick-edge to Overflow/COUNT update = 1 edge.

Reset
REQ-027 SHALL on RST=1 at a rising edge set DUR[0..5]=DEF_DUR, COUNT=0, prescaler=0, S_prev=0, Overflow=0, ERR=0.
REQ-028 SHALL ignore WE, CLR, EN and S while RST=1; first one-hot S after RST release triggers reload.
REQ-029 SHALL abort any dwell in progress when RST asserts mid-count, with no Overflow pulse.

Verification
REQ-030 TICK_DIV=1, DUR[0]=3, S=000001 after reset -> COUNT 3,2,1,0 on consecutive edges; Overflow=1 only with COUNT=0, one cycle.
REQ-031 TICK_DIV=10, defaults, S switches 000001->000010 -> reload COUNT=4; Overflow 40 cycles after reload, exactly one pulse.
REQ-032 CLR pulsed at COUNT=2 with DUR=5 -> COUNT=5 next edge, prescaler=0, Overflow delayed accordingly.
REQ-033 S=000011 for 3 cycles mid-dwell -> ERR=1, COUNT=0, no Overflow; S=000100 -> ERR=0, COUNT=DUR[2].
REQ-034 WE WADDR=2 WDATA=7 same cycle S changes to 000100 -> COUNT=7; WADDR=6 write -> no register changes.
REQ-035 RST at COUNT=2 -> next edge COUNT=0, Overflow=0, DUR all 4; EN=0 for 20 cycles -> COUNT frozen.

Source files
------------

// File: rtl/dwell_timer.sv
// Per-state dwell timer: reloads on state change or CLR, counts down prescaled ticks, pulses Overflow at expiry.
// All outputs registered; one edge from tick to COUNT/Overflow update; EN low freezes the prescaler and COUNT.
module dwell_timer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 10,
    parameter int DEF_DUR  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             EN,
    input  logic [5:0]       S,
    input  logic             WE,
    input  logic [2:0]       WADDR,
    input  logic [WIDTH-1:0] WDATA,
    output logic             Overflow,
    output logic [WIDTH-1:0] COUNT,
    output logic             ERR
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [WIDTH-1:0] dur_q [6];
    logic [WIDTH-1:0] dur_d [6];
    logic [5:0]       s_prev_q, s_prev_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             s_onehot;
    logic [2:0]       s_idx;
    logic [WIDTH-1:0] dur_sel;
    logic [WIDTH-1:0] reload_val;
    logic             reload;
    logic             tick_last;

    always_comb begin
        s_onehot = (S != 6'd0) && ((S & (S - 6'd1)) == 6'd0);
        s_idx    = 3'd0;
        dur_sel  = dur_q[0];
        for (int i = 0; i < 6; i++) begin
            if (S[i]) begin
                s_idx   = 3'(i);
                dur_sel = dur_q[i];
            end
        end
        // A write landing on the register being reloaded must be seen by that reload.
        reload_val = (WE && (WADDR == s_idx)) ? WDATA : dur_sel;
        reload     = (S != s_prev_q) || CLR;
        tick_last  = (presc_q == PW'(TICK_DIV - 1));
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            dur_d[i] = (WE && (WADDR == 3'(i))) ? WDATA : dur_q[i];
        end
        s_prev_d = S;
        count_d  = count_q;
        presc_d  = presc_q;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        if (!s_onehot) begin
            err_d   = 1'b1;
            count_d = '0;
            presc_d = '0;
        end else if (reload) begin
            count_d = reload_val;
            presc_d = '0;
        end else if (EN && (count_q != '0)) begin
            if (tick_last) begin
                presc_d = '0;
                count_d = count_q - WIDTH'(1);
                ovf_d   = (count_q == WIDTH'(1));
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 6; i++) begin
                dur_q[i] <= WIDTH'(DEF_DUR);
            end
            s_prev_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                dur_q[i] <= dur_d[i];
            end
            s_prev_q <= s_prev_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign Overflow = ovf_q;
    assign COUNT    = count_q;
    assign ERR      = err_q;
endmodule

// File: tb/tb_dwell_timer.sv
// Bench for dwell_timer: two instances (TICK_DIV 1 and 10) against an elapsed-cycle reference model.
module tb_dwell_timer;
    logic       CLK = 1'b0;
    logic       RST, CLR, EN, WE;
    logic [5:0] S;
    logic [2:0] WADDR;
    logic [7:0] WDATA;
    logic       ovf_a, err_a, ovf_b, err_b;
    logic [7:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dwell_timer #(.WIDTH(8), .TICK_DIV(1), .DEF_DUR(4)) u_a (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .S(S), .WE(WE),
        .WADDR(WADDR), .WDATA(WDATA), .Overflow(ovf_a), .COUNT(count_a), .ERR(err_a)
    );
    dwell_timer #(.WIDTH(8), .TICK_DIV(10), .DEF_DUR(4)) u_b (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .S(S), .WE(WE),
        .WADDR(WADDR), .WDATA(WDATA), .Overflow(ovf_b), .COUNT(count_b), .ERR(err_b)
    );

    // Reference model: a dwell is "load ticks" long; elapsed enabled cycles since reload
    // determine the remaining count as load - elapsed/TICK_DIV.
    int td    [2] = '{1, 10};
    int m_dur [2][6];
    int m_load[2];
    int m_el  [2];
    int m_ovf [2];
    int m_err [2];
    int m_prev[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int remaining(input int k);
        if (m_load[k] == 0) return 0;
        return m_load[k] - m_el[k] / td[k];
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                for (int r = 0; r < 6; r++) m_dur[k][r] = 4;
                m_load[k] = 0; m_el[k] = 0; m_prev[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
            end else begin
                int idx, eff;
                idx = 0;
                for (int r = 0; r < 6; r++) if (S[r]) idx = r;
                eff = (WE && int'(WADDR) == idx) ? int'(WDATA) : m_dur[k][idx];
                m_ovf[k] = 0;
                if ($countones(S) != 1) begin
                    m_err[k] = 1; m_load[k] = 0; m_el[k] = 0;
                end else begin
                    m_err[k] = 0;
                    if (int'(S) != m_prev[k] || CLR) begin
                        m_load[k] = eff; m_el[k] = 0;
                    end else if (EN && remaining(k) > 0) begin
                        m_el[k]++;
                        if (m_el[k] == m_load[k] * td[k]) m_ovf[k] = 1;
                    end
                end
                if (WE && WADDR < 3'd6) m_dur[k][WADDR] = int'(WDATA);
                m_prev[k] = int'(S);
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared just after it, then back to the falling edge.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        chk("a.count", 32'(count_a), 32'(remaining(0)));
        chk("a.ovf",   32'(ovf_a),   32'(m_ovf[0]));
        chk("a.err",   32'(err_a),   32'(m_err[0]));
        chk("b.count", 32'(count_b), 32'(remaining(1)));
        chk("b.ovf",   32'(ovf_b),   32'(m_ovf[1]));
        chk("b.err",   32'(err_b),   32'(m_err[1]));
        @(negedge CLK);
    endtask

    initial begin
        int first_at, pulses, frozen;
        RST = 1'b1; CLR = 1'b0; EN = 1'b1; WE = 1'b0; S = 6'd0; WADDR = 3'd0; WDATA = 8'd0;
        @(negedge CLK);
        cycle(); cycle();
        chk("rst.count", 32'(count_b), 32'd0);
        chk("rst.ovf",   32'(ovf_b),   32'd0);
        chk("rst.err",   32'(err_b),   32'd0);

        // TICK_DIV=1, DUR[0]=3 written while entering S0: COUNT 3,2,1,0.
        RST = 1'b0; S = 6'b000001; WE = 1'b1; WADDR = 3'd0; WDATA = 8'd3;
        cycle();
        WE = 1'b0;
        chk("td1.c3", 32'(count_a), 32'd3);
        cycle(); chk("td1.c2", 32'(count_a), 32'd2);
        cycle(); chk("td1.c1", 32'(count_a), 32'd1); chk("td1.noovf", 32'(ovf_a), 32'd0);
        cycle(); chk("td1.c0", 32'(count_a), 32'd0); chk("td1.ovf", 32'(ovf_a), 32'd1);
        cycle(); chk("td1.hold", 32'(count_a), 32'd0); chk("td1.once", 32'(ovf_a), 32'd0);

        // TICK_DIV=10, default DUR[1]=4: Overflow exactly 40 cycles after reload.
        S = 6'b000010;
        cycle();
        chk("td10.load", 32'(count_b), 32'd4);
        first_at = 0; pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            cycle();
            if (ovf_b) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        chk("td10.ovf_at", 32'(first_at), 32'd40);
        chk("td10.pulses", 32'(pulses), 32'd1);

        // CLR mid-dwell with DUR[1]=5 restarts the dwell.
        WE = 1'b1; WADDR = 3'd1; WDATA = 8'd5; CLR = 1'b1;
        cycle();
        WE = 1'b0; CLR = 1'b0;
        chk("clr.load", 32'(count_b), 32'd5);
        repeat (30) cycle();
        chk("clr.mid", 32'(count_b), 32'd2);
        CLR = 1'b1; cycle(); CLR = 1'b0;
        chk("clr.reload", 32'(count_b), 32'd5);

        // Multi-hot S: ERR, COUNT cleared, then recovery reloads DUR[2].
        S = 6'b000011;
        repeat (3) cycle();
        chk("err.flag", 32'(err_b), 32'd1);
        chk("err.count", 32'(count_b), 32'd0);
        S = 6'b000100; cycle();
        chk("err.clear", 32'(err_b), 32'd0);
        chk("err.reload", 32'(count_b), 32'd4);

        // Write forwarding into a coinciding reload; WADDR 6 changes nothing.
        WE = 1'b1; WADDR = 3'd6; WDATA = 8'd9; cycle();
        WADDR = 3'd3; WDATA = 8'd7; S = 6'b001000; cycle();
        WE = 1'b0;
        chk("fwd.count", 32'(count_b), 32'd7);

        // EN low freezes COUNT.
        repeat (12) cycle();
        frozen = int'(count_b);
        EN = 1'b0;
        repeat (20) cycle();
        chk("en.frozen", 32'(count_b), 32'(frozen));
        EN = 1'b1;

        // Reset mid-count aborts without Overflow.
        RST = 1'b1; cycle(); RST = 1'b0;
        chk("rstmid.count", 32'(count_b), 32'd0);
        chk("rstmid.ovf", 32'(ovf_b), 32'd0);

        for (int n = 0; n < 4000; n++) begin
            RST = ($urandom_range(299) == 0);
            CLR = ($urandom_range(79) == 0);
            EN  = ($urandom_range(9) != 0);
            WE  = ($urandom_range(14) == 0);
            WADDR = 3'($urandom_range(7));
            WDATA = 8'($urandom_range(6));
            if ($urandom_range(89) == 0) S = 6'b1 << $urandom_range(5);
            else if ($urandom_range(249) == 0) S = 6'($urandom_range(63));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
